instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the combinational instruction ROM (addr in -> 32-bit instr out, same cycle).
//  - Owns the fetch PC and drives the ROM address.
//  - Buffers fetched words in a DEPTH-entry prefetch FIFO, drained through a valid/ready port to decode.
//  - Handles redirects (jump/branch) and stops on the self-loop halt instruction.
// PARAMETERS
//  ADDR_W      8             ROM word-address width; PC is a word address
//  DEPTH       4             prefetch FIFO entries (power of 2, >=2)
//  ROM_DEPTH   58            populated ROM words; PC >= ROM_DEPTH is out of range
//  RESET_PC    0             fetch PC after reset
//  HALT_INSTR  32'h0000006F  jal x0,0 (self-loop), treated as program end
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  en             in   1        fetch enable
//  rom_addr       out  ADDR_W   ROM address = fetch PC
//  rom_data       in   32       ROM word for rom_addr, valid same cycle
//  redirect_valid in   1        flush and restart fetch at redirect_pc
//  redirect_pc    in   ADDR_W   redirect target word address
//  out_valid      out  1        FIFO head valid
//  out_ready      in   1        decode accepts head
//  out_instr      out  32       head instruction
//  out_pc         out  ADDR_W   head PC
//  out_err        out  1        head PC was out of range
//  fifo_count     out  $clog2(DEPTH+1)  occupied entries
//  halted         out  1        HALT state
// BEHAVIOUR
//  Reset (async, any time, mid-operation included): fetch PC = RESET_PC, FIFO empty, state IDLE.
//   Outputs: out_valid=0, out_err=0, fifo_count=0, halted=0, rom_addr=RESET_PC.
//   out_instr/out_pc = 0.
//  States:
//   IDLE  : en=0; no push. en=1 -> FETCH.
//   FETCH : en=0 -> IDLE. Pushed word == HALT_INSTR -> HALT.
//   HALT  : no push; halted=1. Exit only via redirect (-> FETCH if en, else IDLE) or reset.
//  Push: in FETCH with fifo_count<DEPTH, at the clock edge.
//   - Writes {fetch_pc, rom_data, err} into the FIFO.
//   - fetch_pc <= fetch_pc+1, mod 2^ADDR_W, wraps silently.
//   - No push when full, even if a pop occurs the same cycle (no bypass).
//   - HALT push: fetch_pc is not incremented; rom_addr stays on the halt word.
//  Out of range (fetch_pc >= ROM_DEPTH): entry stores instr 32'h00000013 (NOP) with err=1.
//   Fetching continues normally.
//  Pop: out_valid && out_ready at the edge. FIFO is strictly in order; no loss or duplication.
//   Simultaneous push and pop leaves fifo_count unchanged.
//  Latency: word fetched in cycle N is presented on out_valid in cycle N+1. Sustains 1 instr/cycle.
//  Redirect (highest priority below reset), at the edge:
//   - A same-cycle pop is still accepted.
//   - Then the FIFO is cleared, fetch_pc <= redirect_pc, halted cleared, and nothing is pushed.
//   - Redirect in cycle N -> rom_addr=target in N+1 -> out_valid with out_pc=target in N+2.
//   - A redirect while en=0 updates the PC and goes to IDLE.
//  out_* are FIFO-head registers/array reads and do not depend combinationally on out_ready.
// TESTING
//  1 Reset release, en=1, out_ready=1, ROM model:
//    - out_pc 0,1,2,... each cycle with out_instr=rom[pc].
//    - First out_valid one cycle after the first fetch edge.
//  2 out_ready=0 from start:
//    - fifo_count reaches 4 and rom_addr holds 4.
//    - Release out_ready: out_pc 0,1,2,3,4,... with no gap, loss or duplicate.
//  3 Three entries queued, redirect_valid with redirect_pc=45:
//    - fifo_count=0 next cycle.
//    - Next out_valid shows out_pc=45 two cycles after redirect; no stale entry emitted.
//  4 Run to pc 57 (0x0000006F):
//    - Entry 57 delivered; then halted=1, out_valid=0, rom_addr=57 steady.
//    - Redirect to 0: halted=0, fetch resumes at 0.
//  5 Redirect to 60: out_pc=60, out_instr=0x00000013, out_err=1; pc 61 follows.
//  6 rst_n low mid-stream (fifo_count=3) asynchronously:
//    - out_valid=0, fifo_count=0 and rom_addr=RESET_PC before the next edge.
//    - After release, restart as scenario 1.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the ROM, and buffers
// fetched words in a small in-order prefetch FIFO toward decode.
module instr_fetch_ctrl #(
  parameter int          ADDR_W     = 8,
  parameter int          DEPTH      = 4,
  parameter int          ROM_DEPTH  = 58,
  parameter int          RESET_PC   = 0,
  parameter logic [31:0] HALT_INSTR = 32'h0000006F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       halted
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0]   NOP    = 32'h00000013;
  localparam logic [ADDR_W:0] ROM_LIM = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;

  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [31:0]       mem_instr [DEPTH];
  logic              mem_err   [DEPTH];

  logic        oor;
  logic        is_halt;
  logic        full;
  logic        push;
  logic        pop;
  logic [31:0] wr_instr;

  assign oor      = {1'b0, pc_q} >= ROM_LIM;
  assign wr_instr = oor ? NOP : rom_data;
  assign is_halt  = !oor && (rom_data == HALT_INSTR);
  assign full     = cnt_q == FULL_N;
  assign pop      = (cnt_q != '0) && out_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = FETCH;
      end
      FETCH: begin
        if (!en) begin
          state_d = IDLE;
        end else if (!full) begin
          push = 1'b1;
          if (is_halt) state_d = HALT;
          else         pc_d    = pc_q + 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides everything: flush, retarget, no push.
    if (redirect_valid) begin
      push    = 1'b0;
      pc_d    = redirect_pc;
      state_d = en ? FETCH : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
        mem_err[i]   <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (push) begin
        mem_pc[wp_q]    <= pc_q;
        mem_instr[wp_q] <= wr_instr;
        mem_err[wp_q]   <= oor;
      end
      if (redirect_valid) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign rom_addr   = pc_q;
  assign out_valid  = cnt_q != '0;
  assign out_instr  = mem_instr[rp_q];
  assign out_pc     = mem_pc[rp_q];
  assign out_err    = mem_err[rp_q];
  assign fifo_count = cnt_q;
  assign halted     = state_q == HALT;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboarded bench: expected program-order stream is rebuilt on
// reset/redirect; a negedge monitor checks every accepted head.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        out_err;
  logic [2:0]  fifo_count;
  logic        halted;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] rom [58];
  int          n_chk  = 0;
  int          n_fail = 0;

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_err        (out_err),
    .fifo_count     (fifo_count),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_data = 32'hDEADBEEF;
    if (int'(rom_addr) < 58) rom_data = rom[int'(rom_addr)];
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Program order from s: pc, pc+1, ... through the halt word.
  function automatic void regen(input logic [7:0] s);
    logic [7:0] p;
    ent_t e;
    exp_q.delete();
    p = s;
    for (int k = 0; k < 300; k++) begin
      e.pc    = p;
      e.err   = int'(p) >= 58;
      e.instr = e.err ? 32'h13 : rom[int'(p)];
      exp_q.push_back(e);
      if (!e.err && e.instr == 32'h6F) break;
      p = p + 8'd1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              regen(8'd0);
    else if (redirect_valid) regen(redirect_pc);
  end

  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (fifo_count > 3'd4) check("count_bound", 32'(fifo_count), 32'd4);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_pc", 32'(out_pc), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream_pc", 32'(out_pc), 32'(e.pc));
          check("stream_instr", out_instr, e.instr);
          check("stream_err", 32'(out_err), 32'(e.err));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    redirect_valid = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [7:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 58; i++) begin
      rom[i] = $urandom;
      if (rom[i] == 32'h6F) rom[i] = 32'h12345678;
    end
    rom[57] = 32'h0000006F;
    rst_n = 1'b0;
    en = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_err", 32'(out_err), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", 32'(out_pc), 0);

    // 1: streaming at full rate
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;
    step(1);
    check("s1_no_valid_yet", 32'(out_valid), 0);
    step(1);
    check("s1_first_valid", 32'(out_valid), 1);
    check("s1_first_pc", 32'(out_pc), 0);
    check("s1_addr", 32'(rom_addr), 1);
    step(1);
    check("s1_pc1", 32'(out_pc), 1);
    check("s1_count", 32'(fifo_count), 1);
    step(5);

    // 2: back-pressure fills the FIFO
    do_reset();
    out_ready = 1'b0;
    en = 1'b1;
    step(5);
    check("s2_full", 32'(fifo_count), 4);
    step(3);
    check("s2_full_hold", 32'(fifo_count), 4);
    check("s2_addr_hold", 32'(rom_addr), 4);
    check("s2_head", 32'(out_pc), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("s2_no_gap", 32'(out_valid), 1);
    end

    // 3: redirect with three queued entries
    do_reset();
    out_ready = 1'b0;
    en = 1'b1;
    step(4);
    check("s3_queued", 32'(fifo_count), 3);
    redirect(8'd45);
    check("s3_flush", 32'(fifo_count), 0);
    check("s3_flush_valid", 32'(out_valid), 0);
    check("s3_addr", 32'(rom_addr), 45);
    out_ready = 1'b1;
    step(1);
    check("s3_valid", 32'(out_valid), 1);
    check("s3_pc", 32'(out_pc), 45);

    // 4: run into the halt word
    for (int i = 0; i < 40 && !halted; i++) step(1);
    check("s4_halted", 32'(halted), 1);
    check("s4_head57", 32'(out_pc), 57);
    check("s4_addr57", 32'(rom_addr), 57);
    step(1);
    check("s4_drained", 32'(out_valid), 0);
    step(3);
    check("s4_halt_hold", 32'(halted), 1);
    check("s4_addr_hold", 32'(rom_addr), 57);
    check("s4_count", 32'(fifo_count), 0);
    check("s4_sb_empty", exp_q.size(), 0);
    redirect(8'd0);
    check("s4_unhalt", 32'(halted), 0);
    check("s4_addr0", 32'(rom_addr), 0);
    step(1);
    check("s4_resume", 32'(out_pc), 0);

    // 5: out-of-range fetch
    redirect(8'd60);
    step(1);
    check("s5_pc", 32'(out_pc), 60);
    check("s5_nop", out_instr, 32'h13);
    check("s5_err", 32'(out_err), 1);
    step(1);
    check("s5_pc61", 32'(out_pc), 61);
    check("s5_err61", 32'(out_err), 1);

    // 6: asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b0;
    en = 1'b1;
    step(4);
    check("s6_queued", 32'(fifo_count), 3);
    #3 rst_n = 1'b0;
    #1;
    check("s6_valid", 32'(out_valid), 0);
    check("s6_count", 32'(fifo_count), 0);
    check("s6_addr", 32'(rom_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(2);
    check("s6_restart_valid", 32'(out_valid), 1);
    check("s6_restart_pc", 32'(out_pc), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      en = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 8'($urandom_range(0, 255));
      end else begin
        redirect_valid = 1'b0;
      end
      step(1);
    end
    redirect_valid = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
